// File: rtl/cpu_types_pkg.sv
// Basic datapath types shared by the CPU and its memory-side blocks.
package cpu_types_pkg;

  localparam int unsigned WordW = 32;

  typedef logic [WordW-1:0] word_t;

endpackage

// File: rtl/icache_ctrl_pkg.sv
// Cache types: instruction frame layout and the fetch controller state encoding.
package icache_ctrl_pkg;

  import cpu_types_pkg::*;

  // Sized for the smallest legal cache (2 frames); narrower tags are zero-extended.
  localparam int unsigned FrameTagW = 29;

  typedef enum logic {
    StIdle,
    StFetch
  } icache_state_t;

  typedef struct packed {
    logic                 valid;
    logic [FrameTagW-1:0] tag;
    word_t                data;
  } icachef_t;

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking single-miss fill FSM.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IdxW = $clog2(SETS);

  icache_state_t  state_q;
  icachef_t       frames_q [SETS];
  logic    [31:0] miss_addr_q;
  logic    [31:0] hit_count_q;
  logic    [31:0] miss_count_q;

  logic [IdxW-1:0]      req_idx;
  logic [IdxW-1:0]      fill_idx;
  logic [FrameTagW-1:0] req_tag;
  logic [FrameTagW-1:0] fill_tag;
  icachef_t             req_frame;
  logic                 idle_hit;
  logic                 idle_miss;

  assign req_idx   = imemaddr[2 +: IdxW];
  assign req_tag   = FrameTagW'(imemaddr[31:2+IdxW]);
  assign fill_idx  = miss_addr_q[2 +: IdxW];
  assign fill_tag  = FrameTagW'(miss_addr_q[31:2+IdxW]);
  assign req_frame = frames_q[req_idx];

  assign idle_hit  = (state_q == StIdle) && imemREN && req_frame.valid &&
                     (req_frame.tag == req_tag);
  assign idle_miss = (state_q == StIdle) && imemREN && !idle_hit;

  // Outputs are forced quiet while reset is held, independent of the async flop update.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = imemaddr;
    if (!RST) begin
      case (state_q)
        StIdle: begin
          ihit     = idle_hit;
          imemload = idle_hit ? req_frame.data : '0;
        end
        StFetch: begin
          iREN  = 1'b1;
          iaddr = miss_addr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      miss_addr_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      frames_q     <= '{default: '0};
    end else begin
      if (idle_hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      case (state_q)
        StIdle: begin
          if (idle_miss) begin
            miss_addr_q  <= imemaddr;
            miss_count_q <= miss_count_q + 32'd1;
            state_q      <= StFetch;
          end
        end
        StFetch: begin
          // Request inputs are ignored here; the latched miss always completes.
          if (!iwait) begin
            frames_q[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: iload};
            state_q            <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter SETS, default 16, number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 Signal CLK  input  1  system clock, all state updates on the rising edge.
REQ-003 Signal RST  input  1  reset, asynchronous and active-high.
REQ-004 Signal imemREN  input  1  fetch request from the datapath.
REQ-005 Signal imemaddr  input  32  fetch byte address, word aligned.
REQ-006 Signal ihit  output  1  imemload valid for imemaddr this cycle.
REQ-007 Signal imemload  output  32  instruction word.
REQ-008 Signal iREN  output  1  read request to the memory controller.
REQ-009 Signal iaddr  output  32  memory read address.
REQ-010 Signal iwait  input  1  memory busy; data is valid when iwait=0 and iREN=1.
REQ-011 Signal iload  input  32  memory read data.
REQ-012 Signal hit_count  output  32  count of cycles with ihit=1.
REQ-013 Signal miss_count  output  32  count of accepted misses.

Function
REQ-014 Address split: byte offset [1:0] ignored; index = [2+log2(SETS)-1:2]; tag = [31:2+log2(SETS)].
REQ-015 Each frame holds valid (1 b), tag, and data (32 b).
REQ-016 The FSM has two states: IDLE and FETCH.
REQ-017 IDLE hit: imemREN=1 and frame[index] is valid with matching tag -> ihit=1 combinationally and imemload=frame data in the same cycle.
REQ-018 IDLE miss: imemREN=1 with no hit -> ihit=0; latch imemaddr into miss_addr; move to FETCH next edge; increment miss_count.
REQ-019 IDLE with imemREN=0 -> ihit=0, iREN=0, and the state does not change.
REQ-020 FETCH: iREN=1 and iaddr=miss_addr every cycle; ihit=0.
REQ-021 FETCH with iwait=0: write frame[miss_addr index] with valid=1, tag, and iload; return to IDLE on the same edge.
REQ-022 After a fill, the refetched address hits on the first cycle back in IDLE, so miss latency = memory cycles + 1.
REQ-023 Changes to imemaddr or imemREN during FETCH are ignored; the latched fill completes unaborted.
REQ-024 If iwait=0 in the first FETCH cycle, the fill completes in that cycle.
REQ-025 In IDLE: iREN=0 and iaddr=imemaddr.
REQ-026 When ihit=0, imemload=0.
REQ-027 A fill replaces any existing valid frame at the same index (conflict eviction); no other frame changes.
REQ-028 hit_count and miss_count wrap modulo 2^32.

Reset
REQ-029 RST=1 forces: state=IDLE; all valid bits=0; miss_addr=0; hit_count=0; miss_count=0.
REQ-030 Outputs while RST=1: ihit=0, iREN=0, imemload=0.
REQ-031 RST asserted during FETCH abandons the fill; no frame is written.
REQ-032 After RST deasserts, the first request misses.

Structure
REQ-033 The frame struct type icachef_t (valid, tag, data) and the icache_state_t enum belong in a shared cache types package; word_t comes from cpu_types_pkg.
REQ-034 The block is a single module with no sub-modules.
REQ-035 Frame storage is a register array of SETS entries.

Verification
REQ-036 Cold miss: reset, then imemREN=1, imemaddr=0x00000040, memory latency 3 -> iREN=1 with iaddr=0x40 for 3 cycles; ihit=1 next cycle; miss_count=1.
REQ-037 Hit: repeat 0x40 for 5 cycles -> ihit=1 all 5 cycles, iREN=0, hit_count advances by 5.
REQ-038 Conflict: fill 0x00000000 then fetch 0x00000040 (SETS=16, same index 0) -> 0x40 misses; 0x00 misses again afterwards.
REQ-039 Address change mid-fetch: miss on 0x80, then switch to 0x84 during FETCH -> iaddr stays 0x80; 0x80 is filled; 0x84 then misses.
REQ-040 Reset mid-fetch: RST pulsed during FETCH for 0x100 -> iREN=0 immediately; a later fetch of 0x100 misses.
REQ-041 Zero-latency memory: iwait=0 always -> every miss takes exactly 1 FETCH cycle, then hits.
